// File: rtl/sram_bus_fabric.sv
// Address-decoded SRAM bus fabric: channel chip-select/read-mux, phase counter, IRQ sync.
// Optional wait-state watchdog enabled by defining SRAM_BUS_TIMEOUT_EN.
module sram_bus_fabric #(
  parameter int SEL_BITS = 2,
  parameter int SEL_LSB  = 10,
  localparam int NCH     = 2 ** SEL_BITS,
  parameter logic [NCH-1:0] GATE_MASK = 'b0011,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [15:0]         sram_a,
  input  logic                sram_cs,
  input  logic                sram_oe,
  input  logic                sram_we,
  output logic [7:0]          sram_d_out,
  output logic                sram_wait,
  output logic [NCH-1:0]      ch_cs,
  input  logic [NCH*8-1:0]    ch_d,
  input  logic [NCH-1:0]      ch_wait,
  input  logic [NCH-1:0]      ch_irq,
  output logic [1:0]          phase,
  output logic                cpu_clk_en,
  output logic                irq_out,
  output logic [SEL_BITS-1:0] irq_src,
  output logic                timeout_err,
  output logic [SEL_BITS-1:0] err_ch,
  input  logic                timeout_clr
);

  logic [SEL_BITS-1:0] sel;
  logic                hit;

  assign sel        = sram_a[SEL_LSB +: SEL_BITS];
  assign hit        = sram_cs & ch_wait[sel];
  assign sram_d_out = ch_d[{sel, 3'b000} +: 8];
  assign cpu_clk_en = (phase == 2'd0);

  // Strobes are decoded by the channel devices themselves, not here.
  logic unused_strobes;
  assign unused_strobes = sram_oe ^ sram_we;

  // NOTE: every output written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    ch_cs = '0;
    for (int i = 0; i < NCH; i++)
      ch_cs[i] = sram_cs && (sel == SEL_BITS'(i)) && (!GATE_MASK[i] || phase == 2'd0);
  end

  function automatic logic [SEL_BITS-1:0] lowest_set(input logic [NCH-1:0] v);
    lowest_set = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (v[i]) lowest_set = SEL_BITS'(i);
  endfunction

  // Second sync stage loads only in phase-0 cycles; irq_out/irq_src follow its next value.
  logic [NCH-1:0] irq_sync1, irq_sync2, irq_sync2_next;
  assign irq_sync2_next = (phase == 2'd0) ? irq_sync1 : irq_sync2;

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      phase     <= 2'd0;
      irq_sync1 <= '0;
      irq_sync2 <= '0;
      irq_out   <= 1'b0;
      irq_src   <= '0;
    end else begin
      phase <= phase + 2'd1;
      if (phase == 2'd0) irq_sync1 <= ch_irq;
      irq_sync2 <= irq_sync2_next;
      irq_out   <= |irq_sync2_next;
      if (|irq_sync2_next) irq_src <= lowest_set(irq_sync2_next);
    end
  end

`ifdef SRAM_BUS_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wait_cnt;
  logic        force_low;
  logic        expire;

  // Expiry fires on the TIMEOUT-th consecutive waited cycle of one access.
  assign expire    = hit && !force_low && (wait_cnt == TIMEOUT_LAST);
  assign sram_wait = hit & ~force_low;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wait_cnt    <= '0;
      force_low   <= 1'b0;
      timeout_err <= 1'b0;
      err_ch      <= '0;
    end else begin
      if (!hit)            wait_cnt <= '0;
      else if (!force_low) wait_cnt <= wait_cnt + 16'd1;

      if (expire)       force_low <= 1'b1;
      else if (!sram_cs) force_low <= 1'b0;

      if (expire) begin
        timeout_err <= 1'b1;
        err_ch      <= sel;
      end else if (timeout_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end
`else
  assign sram_wait   = hit;
  assign timeout_err = 1'b0;
  assign err_ch      = '0;

  logic unused_timeout_clr;
  assign unused_timeout_clr = timeout_clr;
`endif

endmodule
